// File: rtl/bmp_line_loader_if.sv
// bmp_line_loader_if
//   Groups the UART byte handshake and the line-BRAM write port of
//   bmp_line_loader, together with its frame status outputs.
//   Signals:
//     rx_ready    UART byte available        (driver -> loader)
//     rx_data     UART byte                  (driver -> loader)
//     rx_trigger  one-cycle byte acknowledge (loader -> driver)
//     line_addr   BRAM write address
//     line_data   BRAM write data (ROWSIZE cells + two guard bits)
//     bram_ce     BRAM chip enable
//     bram_we     BRAM write enable
//     busy        frame load in progress
//     frame_ready one-cycle pulse after the last guard-row write
//     error       one-cycle pulse on abort
//     err_code    cause of the last abort
//   Modports: master = loader side, slave = UART/BRAM/engine side.
interface bmp_line_loader_if #(
    parameter int ROWSIZE    = 64,
    parameter int ADDRLENGTH = 7
);
    logic                  rx_ready;
    logic [7:0]            rx_data;
    logic                  rx_trigger;
    logic [ADDRLENGTH-1:0] line_addr;
    logic [ROWSIZE+1:0]    line_data;
    logic                  bram_ce;
    logic                  bram_we;
    logic                  busy;
    logic                  frame_ready;
    logic                  error;
    logic [2:0]            err_code;

    modport master (
        input  rx_ready, rx_data,
        output rx_trigger, line_addr, line_data, bram_ce, bram_we,
               busy, frame_ready, error, err_code
    );

    modport slave (
        output rx_ready, rx_data,
        input  rx_trigger, line_addr, line_data, bram_ce, bram_we,
               busy, frame_ready, error, err_code
    );
endinterface

// File: rtl/bmp_line_loader.sv
// bmp_line_loader
//   Hunts the UART byte stream for a 24-bit BMP header, validates it,
//   thresholds every BGR pixel to one live/dead cell, packs each image row
//   (with zero guard bits at bit 0 and bit ROWSIZE+1) into one BRAM word,
//   then writes the two all-zero guard rows and pulses frame_ready.
//   Ports:
//     clk_main  clock
//     reset     synchronous active-high reset
//     bus       bmp_line_loader_if.master (UART handshake, BRAM write port,
//               busy / frame_ready / error / err_code status)
//   err_code: 1 bpp, 2 width, 3 |height|, 4 compression, 5 offset, 6 timeout.
module bmp_line_loader #(
    parameter int ROWSIZE    = 64,
    parameter int COLSIZE    = 64,
    parameter int ADDRLENGTH = 7,
    parameter int THRESH     = 128,
    parameter int TIMEOUT    = 2_500_000
) (
    input  logic               clk_main,
    input  logic               reset,
    bmp_line_loader_if.master  bus
);
    localparam int XW        = $clog2(ROWSIZE + 1);
    localparam int PAD_BYTES = (4 - ((3 * ROWSIZE) % 4)) % 4;

    localparam logic [3:0] S_HUNT_B = 4'd0;
    localparam logic [3:0] S_HUNT_M = 4'd1;
    localparam logic [3:0] S_HEADER = 4'd2;
    localparam logic [3:0] S_SKIP   = 4'd3;
    localparam logic [3:0] S_PIXEL  = 4'd4;
    localparam logic [3:0] S_PAD    = 4'd5;
    localparam logic [3:0] S_WRITE  = 4'd6;
    localparam logic [3:0] S_GUARD0 = 4'd7;
    localparam logic [3:0] S_GUARD1 = 4'd8;
    localparam logic [3:0] S_DONE   = 4'd9;

    logic [3:0]            r_state;
    logic                  r_rx_trigger;
    logic [ADDRLENGTH-1:0] r_line_addr;
    logic [ROWSIZE+1:0]    r_line_data;
    logic                  r_bram_ce;
    logic                  r_bram_we;
    logic                  r_busy;
    logic                  r_frame_ready;
    logic                  r_error;
    logic [2:0]            r_err_code;

    logic [5:0]            r_byte_idx;
    logic [31:0]           r_offset;
    logic [31:0]           r_width;
    logic [31:0]           r_height;
    logic [15:0]           r_bpp;
    logic [31:0]           r_comp;
    logic [31:0]           r_skip;
    logic [31:0]           r_idle;
    logic                  r_topdown;
    logic [ADDRLENGTH-1:0] r_row_addr;
    logic [ADDRLENGTH-1:0] r_rows;
    logic [ROWSIZE+1:0]    r_row;
    logic [XW-1:0]         r_x;
    logic [1:0]            r_phase;
    logic [1:0]            r_pad;
    logic                  r_alive;

    logic                  w_timed;
    logic                  w_consume;
    logic                  w_accept;
    logic                  w_timeout;
    logic                  w_hot;
    logic [31:0]           w_abs_height;
    logic [2:0]            w_code;
    logic [ROWSIZE+1:0]    w_onehot;
    logic [ROWSIZE+1:0]    w_row_set;

    assign w_timed   = (r_state == S_HEADER) || (r_state == S_SKIP) ||
                       (r_state == S_PIXEL)  || (r_state == S_PAD);
    assign w_consume = w_timed || (r_state == S_HUNT_B) || (r_state == S_HUNT_M);
    // The acknowledge cycle blocks acceptance, capping throughput at one byte per two cycles.
    assign w_accept  = bus.rx_ready && !r_rx_trigger && w_consume;
    assign w_timeout = w_timed && !w_accept && (r_idle == 32'(TIMEOUT));
    assign w_hot     = (bus.rx_data >= 8'(THRESH));

    assign w_abs_height = r_height[31] ? (~r_height + 32'd1) : r_height;

    // Header checks in priority order; all fields are complete once byte 53 arrives.
    always_comb begin
        w_code = 3'd0;
        if (r_bpp != 16'd24)                    w_code = 3'd1;
        else if (r_width != 32'(ROWSIZE))       w_code = 3'd2;
        else if (w_abs_height != 32'(COLSIZE))  w_code = 3'd3;
        else if (r_comp != 32'd0)               w_code = 3'd4;
        else if (r_offset < 32'd54)             w_code = 3'd5;
    end

    // Row buffer with the cell of the current pixel (bit x+1) merged in.
    assign w_onehot  = {{(ROWSIZE+1){1'b0}}, 1'b1} << (r_x + XW'(1));
    assign w_row_set = (r_alive || w_hot) ? (r_row | w_onehot) : r_row;

    always_ff @(posedge clk_main) begin
        if (reset) begin
            r_state       <= S_HUNT_B;
            r_rx_trigger  <= 1'b0;
            r_line_addr   <= '0;
            r_line_data   <= '0;
            r_bram_ce     <= 1'b0;
            r_bram_we     <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_ready <= 1'b0;
            r_error       <= 1'b0;
            r_err_code    <= '0;
            r_byte_idx    <= '0;
            r_offset      <= '0;
            r_width       <= '0;
            r_height      <= '0;
            r_bpp         <= '0;
            r_comp        <= '0;
            r_skip        <= '0;
            r_idle        <= '0;
            r_topdown     <= 1'b0;
            r_row_addr    <= '0;
            r_rows        <= '0;
            r_row         <= '0;
            r_x           <= '0;
            r_phase       <= '0;
            r_pad         <= '0;
            r_alive       <= 1'b0;
        end else begin
            r_rx_trigger  <= w_accept;
            r_bram_ce     <= 1'b0;
            r_bram_we     <= 1'b0;
            r_frame_ready <= 1'b0;
            r_error       <= 1'b0;

            if (!w_timed || w_accept || w_timeout) r_idle <= '0;
            else                                   r_idle <= r_idle + 32'd1;

            if (w_timeout) begin
                r_error    <= 1'b1;
                r_err_code <= 3'd6;
                r_busy     <= 1'b0;
                r_state    <= S_HUNT_B;
            end else begin
                // Strobes are loaded on the edge that enters WRITE/GUARD*,
                // so each strobe is high during the cycle named by the state.
                case (r_state)
                    S_HUNT_B: begin
                        if (w_accept && bus.rx_data == 8'h42) r_state <= S_HUNT_M;
                    end
                    S_HUNT_M: begin
                        if (w_accept) begin
                            if (bus.rx_data == 8'h4D) begin
                                r_state    <= S_HEADER;
                                r_byte_idx <= 6'd2;
                                r_busy     <= 1'b1;
                            end else if (bus.rx_data != 8'h42) begin
                                r_state <= S_HUNT_B;
                            end
                        end
                    end
                    S_HEADER: begin
                        if (w_accept) begin
                            // Little-endian fields shift in from the top.
                            if (r_byte_idx >= 6'd10 && r_byte_idx <= 6'd13) r_offset <= {bus.rx_data, r_offset[31:8]};
                            if (r_byte_idx >= 6'd18 && r_byte_idx <= 6'd21) r_width  <= {bus.rx_data, r_width[31:8]};
                            if (r_byte_idx >= 6'd22 && r_byte_idx <= 6'd25) r_height <= {bus.rx_data, r_height[31:8]};
                            if (r_byte_idx >= 6'd28 && r_byte_idx <= 6'd29) r_bpp    <= {bus.rx_data, r_bpp[15:8]};
                            if (r_byte_idx >= 6'd30 && r_byte_idx <= 6'd33) r_comp   <= {bus.rx_data, r_comp[31:8]};
                            r_byte_idx <= r_byte_idx + 6'd1;
                            if (r_byte_idx == 6'd53) begin
                                if (w_code != 3'd0) begin
                                    r_error    <= 1'b1;
                                    r_err_code <= w_code;
                                    r_busy     <= 1'b0;
                                    r_state    <= S_HUNT_B;
                                end else begin
                                    r_topdown  <= r_height[31];
                                    r_row_addr <= r_height[31] ? ADDRLENGTH'(1) : ADDRLENGTH'(COLSIZE);
                                    r_rows     <= '0;
                                    r_row      <= '0;
                                    r_x        <= '0;
                                    r_phase    <= '0;
                                    r_pad      <= '0;
                                    r_alive    <= 1'b0;
                                    r_skip     <= r_offset - 32'd54;
                                    r_state    <= (r_offset == 32'd54) ? S_PIXEL : S_SKIP;
                                end
                            end
                        end
                    end
                    S_SKIP: begin
                        if (w_accept) begin
                            r_skip <= r_skip - 32'd1;
                            if (r_skip == 32'd1) r_state <= S_PIXEL;
                        end
                    end
                    S_PIXEL: begin
                        if (w_accept) begin
                            case (r_phase)
                                2'd0: begin
                                    r_alive <= w_hot;
                                    r_phase <= 2'd1;
                                end
                                2'd1: begin
                                    r_alive <= r_alive | w_hot;
                                    r_phase <= 2'd2;
                                end
                                default: begin
                                    r_phase <= 2'd0;
                                    r_row   <= w_row_set;
                                    if (r_x == XW'(ROWSIZE - 1)) begin
                                        if (PAD_BYTES == 0) begin
                                            r_bram_ce   <= 1'b1;
                                            r_bram_we   <= 1'b1;
                                            r_line_addr <= r_row_addr;
                                            r_line_data <= {1'b0, w_row_set[ROWSIZE:1], 1'b0};
                                            r_state     <= S_WRITE;
                                        end else begin
                                            r_pad   <= '0;
                                            r_state <= S_PAD;
                                        end
                                    end else begin
                                        r_x <= r_x + XW'(1);
                                    end
                                end
                            endcase
                        end
                    end
                    S_PAD: begin
                        if (w_accept) begin
                            if (r_pad == 2'(PAD_BYTES - 1)) begin
                                r_bram_ce   <= 1'b1;
                                r_bram_we   <= 1'b1;
                                r_line_addr <= r_row_addr;
                                r_line_data <= {1'b0, r_row[ROWSIZE:1], 1'b0};
                                r_state     <= S_WRITE;
                            end else begin
                                r_pad <= r_pad + 2'd1;
                            end
                        end
                    end
                    S_WRITE: begin
                        r_row   <= '0;
                        r_x     <= '0;
                        r_phase <= '0;
                        if (r_rows == ADDRLENGTH'(COLSIZE - 1)) begin
                            r_bram_ce   <= 1'b1;
                            r_bram_we   <= 1'b1;
                            r_line_addr <= '0;
                            r_line_data <= '0;
                            r_state     <= S_GUARD0;
                        end else begin
                            r_rows     <= r_rows + ADDRLENGTH'(1);
                            r_row_addr <= r_topdown ? (r_row_addr + ADDRLENGTH'(1))
                                                    : (r_row_addr - ADDRLENGTH'(1));
                            r_state    <= S_PIXEL;
                        end
                    end
                    S_GUARD0: begin
                        r_bram_ce   <= 1'b1;
                        r_bram_we   <= 1'b1;
                        r_line_addr <= ADDRLENGTH'(COLSIZE + 1);
                        r_line_data <= '0;
                        r_state     <= S_GUARD1;
                    end
                    S_GUARD1: begin
                        r_frame_ready <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_DONE;
                    end
                    S_DONE: begin
                        r_state <= S_HUNT_B;
                    end
                    default: begin
                        r_state <= S_HUNT_B;
                    end
                endcase
            end
        end
    end

    assign bus.rx_trigger  = r_rx_trigger;
    assign bus.line_addr   = r_line_addr;
    assign bus.line_data   = r_line_data;
    assign bus.bram_ce     = r_bram_ce;
    assign bus.bram_we     = r_bram_we;
    assign bus.busy        = r_busy;
    assign bus.frame_ready = r_frame_ready;
    assign bus.error       = r_error;
    assign bus.err_code    = r_err_code;
endmodule

// File: tb/tb_bmp_line_loader.sv
// tb_bmp_line_loader
//   Drives BMP byte streams into bmp_line_loader through its interface and
//   compares every BRAM write, status pulse and error code against values
//   computed from the image contents and header fields.
module tb_bmp_line_loader;
    localparam int ROWSIZE    = 10;
    localparam int COLSIZE    = 6;
    localparam int ADDRLENGTH = 3;
    localparam int THRESH     = 128;
    localparam int TIMEOUT    = 300;
    localparam int PAD        = (4 - ((3 * ROWSIZE) % 4)) % 4;

    logic clk_main = 1'b0;
    logic reset    = 1'b1;
    always #5 clk_main = ~clk_main;

    bmp_line_loader_if #(.ROWSIZE(ROWSIZE), .ADDRLENGTH(ADDRLENGTH)) bus ();

    bmp_line_loader #(
        .ROWSIZE(ROWSIZE), .COLSIZE(COLSIZE), .ADDRLENGTH(ADDRLENGTH),
        .THRESH(THRESH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_main(clk_main),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    longint cyc = 0;
    always @(posedge clk_main) cyc <= cyc + 1;

    // Write / pulse monitor
    logic [ADDRLENGTH-1:0] wa[$];
    logic [ROWSIZE+1:0]    wd[$];
    longint                wc[$];
    int     fr_cnt = 0, err_cnt = 0;
    longint fr_cyc = 0, err_cyc = 0;
    always @(negedge clk_main) begin
        if (bus.bram_ce || bus.bram_we) begin
            wa.push_back(bus.line_addr);
            wd.push_back(bus.line_data);
            wc.push_back(cyc);
        end
        if (bus.frame_ready) begin fr_cnt <= fr_cnt + 1; fr_cyc <= cyc; end
        if (bus.error)       begin err_cnt <= err_cnt + 1; err_cyc <= cyc; end
    end

    // Reference image and expectations
    logic [7:0]         pix [COLSIZE][ROWSIZE][3];
    logic [7:0]         bq[$];
    int                 exp_addr [COLSIZE];
    logic [ROWSIZE+1:0] exp_word [COLSIZE];
    longint             t_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit alive(input logic [7:0] b, input logic [7:0] g, input logic [7:0] r);
        return (b >= THRESH) || (g >= THRESH) || (r >= THRESH);
    endfunction

    task automatic gen_pixels(input bit zero);
        for (int r = 0; r < COLSIZE; r++)
            for (int x = 0; x < ROWSIZE; x++) begin
                bit dead = ($urandom_range(0, 1) == 1);
                for (int c = 0; c < 3; c++)
                    pix[r][x][c] = zero ? 8'h00 : (dead ? 8'($urandom_range(0, 127)) : 8'($urandom_range(0, 255)));
            end
    endtask

    task automatic build(input int bpp, input int width, input int height, input int offset, input int comp);
        logic [7:0] h [54];
        bq.delete();
        for (int i = 0; i < 54; i++) h[i] = 8'h00;
        h[0] = 8'h42; h[1] = 8'h4D; h[26] = 8'h01;
        for (int i = 0; i < 4; i++) begin
            h[10+i] = 8'(offset >> (8*i));
            h[18+i] = 8'(width  >> (8*i));
            h[22+i] = 8'(height >> (8*i));
            h[30+i] = 8'(comp   >> (8*i));
        end
        h[28] = 8'(bpp); h[29] = 8'(bpp >> 8);
        for (int i = 0; i < 54; i++) bq.push_back(h[i]);
        for (int i = 54; i < offset; i++) bq.push_back(8'hFF);
        for (int r = 0; r < COLSIZE; r++) begin
            for (int x = 0; x < ROWSIZE; x++)
                for (int c = 0; c < 3; c++) bq.push_back(pix[r][x][c]);
            for (int p = 0; p < PAD; p++) bq.push_back(8'($urandom_range(0, 255)));
        end
        for (int r = 0; r < COLSIZE; r++) begin
            exp_addr[r] = (height > 0) ? (COLSIZE - r) : (1 + r);
            exp_word[r] = '0;
            for (int x = 0; x < ROWSIZE; x++)
                if (alive(pix[r][x][0], pix[r][x][1], pix[r][x][2])) exp_word[r][x+1] = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        n = 0;
        do begin @(negedge clk_main); n++; end while (!bus.rx_trigger && n < 40);
        bus.rx_ready = 1'b0;
        t_last = cyc;
        check("byte_ack", bus.rx_trigger, 1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_trig"},  bus.rx_trigger, 0);
        check({tag, "_ce"},    bus.bram_ce, 0);
        check({tag, "_we"},    bus.bram_we, 0);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_fr"},    bus.frame_ready, 0);
        check({tag, "_err"},   bus.error, 0);
        check({tag, "_code"},  bus.err_code, 0);
        check({tag, "_addr"},  bus.line_addr, 0);
        check({tag, "_data"},  bus.line_data, 0);
    endtask

    task automatic run_frame(input string tag);
        int f0, e0, n;
        wa.delete(); wd.delete(); wc.delete();
        f0 = fr_cnt; e0 = err_cnt;
        foreach (bq[i]) send_byte(bq[i]);
        n = 0;
        while (fr_cnt == f0 && n < 100) begin @(negedge clk_main); n++; end
        repeat (2) @(negedge clk_main);
        check({tag, "_frame_ready_cnt"}, fr_cnt - f0, 1);
        check({tag, "_nwrites"}, wa.size(), COLSIZE + 2);
        for (int i = 0; i < COLSIZE + 2; i++) begin
            if (i < wa.size()) begin
                int ea = (i < COLSIZE) ? exp_addr[i] : ((i == COLSIZE) ? 0 : COLSIZE + 1);
                logic [ROWSIZE+1:0] ed = (i < COLSIZE) ? exp_word[i] : '0;
                check($sformatf("%s_addr%0d", tag, i), wa[i], ea);
                check($sformatf("%s_data%0d", tag, i), wd[i], ed);
            end
        end
        if (wa.size() == COLSIZE + 2) begin
            check({tag, "_lastrow_lat"}, wc[COLSIZE-1] - t_last, 0);
            check({tag, "_guard0_lat"},  wc[COLSIZE] - wc[COLSIZE-1], 1);
            check({tag, "_guard1_lat"},  wc[COLSIZE+1] - wc[COLSIZE], 1);
            check({tag, "_fr_lat"},      fr_cyc - wc[COLSIZE+1], 1);
        end
        check({tag, "_busy_end"}, bus.busy, 0);
        check({tag, "_no_error"}, err_cnt - e0, 0);
    endtask

    int e_bpp [8] = '{32, 24, 24, 24, 24, 24, 32, 24};
    int e_wid [8] = '{10, 11, 10, 10, 10, 10, 11, 11};
    int e_hgt [8] = '{ 6,  6,  7, -7,  6,  6,  7,  7};
    int e_cmp [8] = '{ 0,  0,  0,  0,  1,  0,  1,  1};
    int e_off [8] = '{54, 54, 54, 54, 54, 53, 50, 50};
    int e_cod [8] = '{ 1,  2,  3,  3,  4,  5,  1,  2};

    initial begin
        int e0, f0, n;
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk_main);
        check_reset("reset");
        reset = 1'b0;
        @(negedge clk_main);

        // Single live pixel, bottom-up
        gen_pixels(1);
        pix[0][5][0] = 8'hFF;
        build(24, ROWSIZE, COLSIZE, 0, 0);
        bq.delete(); build(24, ROWSIZE, COLSIZE, 54, 0);
        run_frame("bottomup");
        if (wa.size() > 0) begin
            check("bottomup_pix_addr", wa[0], COLSIZE);
            check("bottomup_pix_word", wd[0], 64'h40);
        end

        // Same image, top-down
        build(24, ROWSIZE, -COLSIZE, 54, 0);
        run_frame("topdown");
        if (wa.size() > 0) check("topdown_pix_addr", wa[0], 1);

        // Garbage before a header
        send_byte(8'h42); check("garbage_busy0", bus.busy, 0);
        send_byte(8'h42); check("garbage_busy1", bus.busy, 0);
        send_byte(8'h13); check("garbage_busy2", bus.busy, 0);
        gen_pixels(0);
        build(24, ROWSIZE, COLSIZE, 54, 0);
        run_frame("garbage_frame");

        // Header rejections
        for (int k = 0; k < 8; k++) begin
            gen_pixels(1);
            build(e_bpp[k], e_wid[k], e_hgt[k], e_off[k], e_cmp[k]);
            wa.delete(); wd.delete(); wc.delete();
            e0 = err_cnt;
            for (int i = 0; i < 54; i++) send_byte(bq[i]);
            repeat (3) @(negedge clk_main);
            check($sformatf("hdr%0d_errpulse", k), err_cnt - e0, 1);
            check($sformatf("hdr%0d_code", k), bus.err_code, e_cod[k]);
            check($sformatf("hdr%0d_err_lat", k), err_cyc - t_last, 0);
            check($sformatf("hdr%0d_nowrites", k), wa.size(), 0);
            check($sformatf("hdr%0d_busy", k), bus.busy, 0);
        end
        gen_pixels(0);
        build(24, ROWSIZE, -COLSIZE, 54, 0);
        run_frame("after_error");
        check("after_error_code_held", bus.err_code, 2);

        // Offset 58 with junk, threshold boundary pixels
        gen_pixels(0);
        pix[0][0][0] = 8'h7F; pix[0][0][1] = 8'h7F; pix[0][0][2] = 8'h7F;
        pix[0][1][0] = 8'h00; pix[0][1][1] = 8'h00; pix[0][1][2] = 8'h80;
        pix[0][2][0] = 8'h7F; pix[0][2][1] = 8'h80; pix[0][2][2] = 8'h7F;
        build(24, ROWSIZE, COLSIZE, 58, 0);
        run_frame("offset58");
        if (wa.size() > 0) begin
            check("offset58_x0_dead",  wd[0][1], 0);
            check("offset58_x1_alive", wd[0][2], 1);
            check("offset58_x2_alive", wd[0][3], 1);
        end

        // Timeout after 100 pixel bytes
        gen_pixels(0);
        build(24, ROWSIZE, COLSIZE, 54, 0);
        wa.delete(); wd.delete(); wc.delete();
        e0 = err_cnt; f0 = fr_cnt;
        for (int i = 0; i < 154; i++) send_byte(bq[i]);
        check("timeout_busy_mid", bus.busy, 1);
        n = 0;
        while (err_cnt == e0 && n < TIMEOUT + 50) begin @(negedge clk_main); n++; end
        repeat (2) @(negedge clk_main);
        check("timeout_errpulse", err_cnt - e0, 1);
        check("timeout_code", bus.err_code, 6);
        check("timeout_window", ((err_cyc - t_last) >= TIMEOUT) && ((err_cyc - t_last) <= TIMEOUT + 1), 1);
        check("timeout_nwrites", wa.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < wa.size()) begin
                check($sformatf("timeout_addr%0d", i), wa[i], exp_addr[i]);
                check($sformatf("timeout_data%0d", i), wd[i], exp_word[i]);
            end
        check("timeout_no_frame", fr_cnt - f0, 0);
        check("timeout_busy", bus.busy, 0);

        // Reset in the middle of a row
        gen_pixels(0);
        build(24, ROWSIZE, COLSIZE, 54, 0);
        for (int i = 0; i < 54 + 15; i++) send_byte(bq[i]);
        wa.delete(); wd.delete(); wc.delete();
        bus.rx_ready = 1'b1;
        bus.rx_data  = 8'h00;
        reset = 1'b1;
        @(negedge clk_main);
        check_reset("midreset");
        reset = 1'b0;
        repeat (30) @(negedge clk_main);
        bus.rx_ready = 1'b0;
        @(negedge clk_main);
        check("midreset_nowrites", wa.size(), 0);
        check("midreset_busy", bus.busy, 0);

        // Recovery frame
        gen_pixels(0);
        build(24, ROWSIZE, -COLSIZE, 54, 0);
        run_frame("recovery");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bmp_line_loader.md
# bmp_line_loader

Upstream loader between the UART driver and the life-pool line BRAM, in the `clk_main` domain. It hunts the UART byte stream for a 24-bit BMP header and validates it. It then thresholds each BGR pixel to one live/dead cell and packs each image row, with zero guard bits, into one BRAM word. Finally it writes the zero guard rows and pulses `frame_ready`, which lets the generation engine start.

## Interface
- `ROWSIZE`, 64: cells per row; must equal the BMP width.
- `COLSIZE`, 64: rows per frame; must equal |BMP height|.
- `ADDRLENGTH`, 7: BRAM address width; 2^ADDRLENGTH ≥ COLSIZE+2.
- `THRESH`, 128: a cell is alive if any of its B, G, R bytes is ≥ THRESH.
- `TIMEOUT`, 2_500_000: idle cycles allowed between bytes mid-frame before abort.
- `clk_main`  in  1  clock; reset reset, synchronous, active-high; clock clk_main.
- `reset`  in  1  synchronous active-high reset.
- `rx_ready`  in  1  UART byte available.
- `rx_data`  in  8  UART byte.
- `rx_trigger`  out  1  one-cycle acknowledge of a consumed byte.
- `line_addr`  out  ADDRLENGTH  BRAM write address.
- `line_data`  out  ROWSIZE+2  BRAM write data.
- `bram_ce`, `bram_we`  out  1  BRAM strobes; both high for exactly one cycle per write.
- `busy`  out  1  a frame is being loaded; downstream generation and display must hold off.
- `frame_ready`  out  1  one-cycle pulse after the last write.
- `error`  out  1  one-cycle pulse on abort.
- `err_code`  out  3  cause of the last abort; held until the next abort.

## Operation
- Byte accept: a byte is consumed in any cycle with `rx_ready && !rx_trigger` while the FSM is in a byte-consuming state. `rx_trigger` is registered high in the following cycle, for one cycle only.
- States: HUNT_B, HUNT_M, HEADER, SKIP, PIXEL, PAD, WRITE, GUARD0, GUARD1, DONE.
- HUNT_B: byte 0x42 → HUNT_M; any other byte is dropped.
- HUNT_M:
  - 0x4D → HEADER, byte index 2, `busy` = 1.
  - 0x42 → stay in HUNT_M.
  - any other byte → HUNT_B.
- HEADER: captures bytes 2..53 as little-endian fields:
  - offset = bytes 10–13, width = 18–21, height = 22–25 (signed), bpp = 28–29, compression = 30–33.
  - Check at byte 53, in priority order: bpp≠24 → code 1; width≠ROWSIZE → code 2; |height|≠COLSIZE → code 3; compression≠0 → code 4; offset<54 → code 5.
  - On any failure: pulse `error`, `busy` = 0, go to HUNT_B.
- SKIP: discards (offset−54) bytes, then → PIXEL. Zero skip goes straight to PIXEL.
- Row order:
  - height > 0 (bottom-up): first file row goes to address COLSIZE, then decrements.
  - height < 0 (top-down): first file row goes to address 1, then increments.
- PIXEL: bytes arrive B, G, R. After R, bit x+1 of the row buffer = (B≥THRESH | G≥THRESH | R≥THRESH), and x increments. After pixel ROWSIZE−1, go to PAD.
- PAD: discards pad = (4 − (3·ROWSIZE mod 4)) mod 4 bytes, then → WRITE. Pad = 0 goes directly to WRITE.
- WRITE: one cycle with `line_addr` = row address, `line_data` = row buffer, bit 0 and bit ROWSIZE+1 forced to 0, ce = we = 1. Then clear the buffer and x.
  - If rows remain → PIXEL.
  - Otherwise → GUARD0.
- GUARD0 / GUARD1: write all-zero words to address 0 and address COLSIZE+1, one cycle each.
- DONE: pulse `frame_ready`, `busy` = 0, → HUNT_B.
- Timeout: in HEADER, SKIP, PIXEL or PAD, an idle counter counts cycles with no accepted byte. When it reaches TIMEOUT: code 6, pulse `error`, → HUNT_B. Rows already written are left in BRAM; no guard rows are written.
- Bytes are not consumed in WRITE, GUARD0, GUARD1 or DONE. `rx_ready` simply stays pending until PIXEL or HUNT_B.
- Unused width bits: `line_addr` and `line_data` hold their last value when ce is low.

## Timing
- Reset values: `rx_trigger`, `bram_ce`, `bram_we`, `busy`, `frame_ready`, `error` = 0; `line_addr` = 0; `line_data` = 0; `err_code` = 0; state HUNT_B; all counters 0.
- Reset mid-frame: takes effect in the next cycle. No further BRAM writes; any pending `rx_trigger` is cancelled.
- Accept-to-acknowledge latency: 1 cycle. Maximum throughput is one byte every 2 cycles.
- Last R byte of a row (zero pad) accepted in cycle n → BRAM write strobe in cycle n+1.
- Final row write in cycle m → guard writes in m+1 and m+2 → `frame_ready` in m+3, with `busy` falling in the same cycle.
- `error` and `err_code` update in the cycle after the offending byte, or the cycle after the timeout is reached.
- Header comparisons use the full 32-bit fields. Height negation is two's-complement, 32 bits.

## Test plan
- Valid 64×64 bottom-up 24-bit BMP, offset 54, one pixel (x=5, file row 0) = FF 00 00 → address 64 = bit 6 only; addresses 0 and 65 = 0; all others 0; exactly 66 writes; one `frame_ready` pulse.
- Same image with height −64 → that pixel appears at address 1; write order 1..64, then 0, 65.
- Garbage 0x42 0x42 0x13 0x42 0x4D then a valid header → frame accepted; garbage never triggers `busy`.
- Header with bpp=32 → `error` pulse, `err_code` = 1, no BRAM writes, `busy` back to 0. A following valid frame loads correctly.
- Offset 58 with 4 junk bytes 0xFF before the pixels → junk is skipped, and the pixel at x=0 is dead when its bytes are 7F 7F 7F (THRESH = 128).
- Stream stopped after 100 pixel bytes → after TIMEOUT idle cycles, `err_code` = 6 and `error` pulses. Separately, reset asserted mid-row → no strobes after reset; outputs at reset values.
